// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter: hands one slave path to N_MASTER masters, holds ownership
// across fixed-length bursts and locked sequences, and parks on master 0 when idle.
module ahb_arbiter #(
  parameter int N_MASTER = 4,
  parameter int MIDX_W   = 2
) (
  input  logic                h_clk,
  input  logic                h_reset,
  input  logic [N_MASTER-1:0] h_busreq,
  input  logic [N_MASTER-1:0] h_lock,
  input  logic [1:0]          h_trans,
  input  logic [2:0]          h_burst,
  input  logic                h_ready,
  input  logic                h_resp,
  output logic [N_MASTER-1:0] h_grant,
  output logic [MIDX_W-1:0]   h_master,
  output logic [MIDX_W-1:0]   h_master_data,
  output logic                h_mastlock,
  output logic [1:0]          dbg_state,
  output logic [MIDX_W-1:0]   dbg_rr_ptr
);

  typedef enum logic [1:0] {
    ST_PARK   = 2'd0,
    ST_XFER   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  state_t                state_q, state_d;
  logic [N_MASTER-1:0]   grant_q, grant_d;
  logic [MIDX_W-1:0]     master_q, master_d;
  logic [MIDX_W-1:0]     master_data_q, master_data_d;
  logic [MIDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [3:0]            beat_cnt_q, beat_cnt_d;
  logic                  incr_q, incr_d;
  logic                  err_q, err_d;

  logic                  is_nonseq, is_seq, incr_now, rp, found;
  logic                  owner_req, owner_lock;
  logic [MIDX_W-1:0]     winner;

  always_ff @(posedge h_clk or posedge h_reset) begin
    if (h_reset) begin
      state_q       <= ST_PARK;
      grant_q       <= N_MASTER'(1);
      master_q      <= '0;
      master_data_q <= '0;
      rr_ptr_q      <= '0;
      beat_cnt_q    <= '0;
      incr_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      master_q      <= master_d;
      master_data_q <= master_data_d;
      rr_ptr_q      <= rr_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      incr_q        <= incr_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    master_d      = master_q;
    master_data_d = master_data_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    incr_d        = incr_q;
    err_d         = err_q;
    found         = 1'b0;
    winner        = '0;

    is_nonseq  = (h_trans == TR_NONSEQ);
    is_seq     = (h_trans == TR_SEQ);
    owner_req  = h_busreq[master_q];
    owner_lock = h_lock[master_q];
    incr_now   = (is_nonseq && h_burst == 3'b001) || (is_seq && incr_q);
    rp = (state_q == ST_PARK) || err_q || (h_trans == TR_IDLE) ||
         (is_nonseq && h_burst == 3'b000) || (is_seq && beat_cnt_q == 4'd1) ||
         (incr_now && !owner_req);

    // Search above the current owner first, then wrap so the owner comes last.
    for (int i = 0; i < N_MASTER; i++) begin
      if (!found && h_busreq[i] && i > int'(master_q)) begin
        found  = 1'b1;
        winner = MIDX_W'(i);
      end
    end
    for (int i = 0; i < N_MASTER; i++) begin
      if (!found && h_busreq[i] && i <= int'(master_q)) begin
        found  = 1'b1;
        winner = MIDX_W'(i);
      end
    end

    if (h_resp && !h_ready) begin
      beat_cnt_d = '0;
      incr_d     = 1'b0;
      err_d      = 1'b1;
    end else if (h_ready) begin
      master_data_d = master_q;
      err_d         = 1'b0;
      if (is_nonseq) begin
        case (h_burst)
          3'b010, 3'b011: beat_cnt_d = 4'd3;
          3'b100, 3'b101: beat_cnt_d = 4'd7;
          3'b110, 3'b111: beat_cnt_d = 4'd15;
          default:        beat_cnt_d = 4'd0;
        endcase
        incr_d = (h_burst == 3'b001);
      end else if (is_seq && beat_cnt_q != 4'd0) begin
        beat_cnt_d = beat_cnt_q - 4'd1;
      end
      if (rp) begin
        if (owner_lock && owner_req) begin
          state_d = ST_LOCKED;
        end else if (found) begin
          master_d = winner;
          rr_ptr_d = winner;
          state_d  = ST_XFER;
        end else begin
          master_d = '0;
          state_d  = ST_PARK;
        end
      end
    end

    grant_d           = '0;
    grant_d[master_d] = 1'b1;
  end

  always_comb begin
    h_grant       = grant_q;
    h_master      = master_q;
    h_master_data = master_data_q;
    h_mastlock    = h_lock[master_q] & h_trans[1];
    dbg_state     = state_q;
    dbg_rr_ptr    = rr_ptr_q;
  end

endmodule
